// File: rtl/trisc_uart_tx_pkg.sv
// Shared I/O definitions for the T-RISC UART transmitter: status bit positions,
// FSM state encodings and the I/O address the core decodes for this port.
package trisc_uart_tx_pkg;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  localparam logic [31:0] IO_ADDR_UART_TX = 32'h0400_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  function automatic logic [7:0] pack_status(input logic ovf, input logic busy,
                                             input logic empty, input logic full);
    logic [7:0] s;
    s           = '0;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_BUSY]  = busy;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/trisc_sync_fifo.sv
// Circular FIFO with a separate occupancy counter; full/empty are registered
// from the next-state level so they line up with the level output.
module trisc_sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  accepted
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam int                  LW      = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic                  full_reg, empty_reg;

  // A pop in the same cycle frees a slot, so a write while full is still taken.
  assign accepted = push && (!full_reg || pop);
  assign rd_data  = mem[rd_ptr_reg];

  always_comb begin
    level_next = level_reg;
    if (accepted && !pop)
      level_next = level_reg + LW'(1);
    else if (!accepted && pop)
      level_next = level_reg - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (accepted)
      mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (accepted)
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      level_reg <= level_next;
      full_reg  <= (level_next == DEPTH_L);
      empty_reg <= (level_next == '0);
    end
  end

  assign level = level_reg;
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/trisc_uart_tx.sv
// T-RISC UART transmitter: buffers core I/O-write bytes and sends them as 8N1
// frames on txd; a status byte is returned to the core for flow control.
module trisc_uart_tx
  import trisc_uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 434,
  parameter int DEPTH_LOG2 = 4,
  parameter int WB         = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [WB-1:0]       wr_data,
  input  logic                clr_ovf,
  output logic                txd,
  output logic [7:0]          status,
  output logic [DEPTH_LOG2:0] level
);

  localparam int          BW        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

  tx_state_t     state_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [WB-1:0] shift_reg;
  logic          txd_reg, busy_reg, ovf_reg;

  logic [WB-1:0] head;
  logic          fifo_full, fifo_empty, fifo_accepted;
  logic          bit_end, pop, drop;

  assign bit_end = (baud_cnt_reg == '0);
  // Popping at the end of STOP lets the next START follow with no idle gap.
  assign pop  = !fifo_empty && ((state_reg == S_IDLE) || (state_reg == S_STOP && bit_end));
  assign drop = wr_en && !fifo_accepted;

  trisc_sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WB)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .pop      (pop),
    .wr_data  (wr_data),
    .rd_data  (head),
    .level    (level),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .accepted (fifo_accepted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          txd_reg <= 1'b1;
          if (pop) begin
            shift_reg    <= head;
            state_reg    <= S_START;
            baud_cnt_reg <= BAUD_LAST;
            txd_reg      <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        S_START: begin
          if (bit_end) begin
            state_reg    <= S_DATA;
            bit_cnt_reg  <= '0;
            baud_cnt_reg <= BAUD_LAST;
            txd_reg      <= shift_reg[0];
          end else begin
            baud_cnt_reg <= baud_cnt_reg - BW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= BAUD_LAST;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= S_STOP;
              txd_reg   <= 1'b1;
            end else begin
              shift_reg   <= shift_reg >> 1;
              txd_reg     <= shift_reg[1];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - BW'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift_reg    <= head;
              state_reg    <= S_START;
              baud_cnt_reg <= BAUD_LAST;
              txd_reg      <= 1'b0;
            end else begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg - BW'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky overflow: a dropped write wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_reg <= 1'b0;
    else if (drop)
      ovf_reg <= 1'b1;
    else if (clr_ovf)
      ovf_reg <= 1'b0;
  end

  assign txd    = txd_reg;
  assign status = pack_status(ovf_reg, busy_reg, fifo_empty, fifo_full);

endmodule

// File: tb/tb_trisc_uart_tx.sv
// Directed bench for trisc_uart_tx with CLK_DIV=4 and a 4-entry FIFO; txd is
// captured every cycle and frames are decoded at bit centres.
module tb_trisc_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_ovf;
  logic       txd;
  logic [7:0] status;
  logic [2:0] level;

  int   cmp_cnt = 0;
  int   err_cnt = 0;
  logic cap [0:511];
  int   cap_n = 0;

  trisc_uart_tx #(.CLK_DIV(4), .DEPTH_LOG2(2), .WB(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_ovf (clr_ovf),
    .txd     (txd),
    .status  (status),
    .level   (level)
  );

  always #5 clk = ~clk;

  // cap[k] holds txd just after the (k+1)-th edge since the last cap_n reset.
  task automatic tick;
    @(posedge clk);
    #1;
    cap[cap_n] = txd;
    cap_n++;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  function automatic logic [7:0] decode(input int base);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = cap[base + 4 * (1 + i) + 1];
    return b;
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    return fr[idx];
  endfunction

  task automatic check_status(input string name, input logic [7:0] exp);
    cmp_cnt++;
    if (status !== exp) begin
      err_cnt++;
      $display("FAIL %s: status got %h expected %h", name, status, exp);
    end
  endtask

  task automatic check_level(input string name, input logic [2:0] exp);
    cmp_cnt++;
    if (level !== exp) begin
      err_cnt++;
      $display("FAIL %s: level got %0d expected %0d", name, level, exp);
    end
  endtask

  task automatic test_reset;
    int high_bad;
    tick(); tick();
    cmp_cnt++;
    if (txd !== 1'b1 || status !== 8'h02 || level !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset_init: txd/status/level got %b/%h/%0d expected 1/02/0", txd, status, level);
    end
    reset = 1'b1;
    tick();
    cap_n = 0;
    write_byte(8'h5A);
    write_byte(8'h3C);
    repeat (10) tick();
    check_level("reset_pre_level", 3'd1);
    #2 reset = 1'b0;
    #1;
    cmp_cnt++;
    if (txd !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_async_txd: got %b expected 1", txd);
    end
    check_status("reset_async_status", 8'h02);
    check_level("reset_async_level", 3'd0);
    tick(); tick();
    reset = 1'b1;
    cap_n = 0;
    repeat (50) tick();
    high_bad = 0;
    for (int i = 0; i < 50; i++) if (cap[i] !== 1'b1) high_bad++;
    cmp_cnt++;
    if (high_bad != 0) begin
      err_cnt++;
      $display("FAIL reset_quiet: low txd cycles got %0d expected 0", high_bad);
    end
    check_status("reset_after_status", 8'h02);
    $display("test_reset done");
  endtask

  task automatic test_single;
    cap_n = 0;
    write_byte(8'h55);
    check_level("single_level", 3'd1);
    cmp_cnt++;
    if (cap[0] !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_latency: txd after write edge got %b expected 1", cap[0]);
    end
    repeat (40) tick();
    for (int i = 0; i < 40; i++) begin
      cmp_cnt++;
      if (cap[1 + i] !== frame_bit(8'h55, i / 4)) begin
        err_cnt++;
        $display("FAIL single_txd cycle %0d: got %b expected %b", i, cap[1 + i], frame_bit(8'h55, i / 4));
      end
    end
    check_status("single_busy_end", 8'h06);
    tick();
    check_status("single_idle", 8'h02);
    $display("test_single done");
  endtask

  task automatic test_back_to_back;
    cap_n = 0;
    write_byte(8'hA3);
    check_level("b2b_level_1", 3'd1);
    write_byte(8'h0F);
    // The write of 0F coincides with the pop of A3, so occupancy holds at 1.
    check_level("b2b_level_2", 3'd1);
    for (int i = 2; i <= 80; i++) begin
      tick();
      if (i == 41) check_level("b2b_level_3", 3'd0);
    end
    for (int i = 0; i < 80; i++) begin
      cmp_cnt++;
      if (cap[1 + i] !== frame_bit((i < 40) ? 8'hA3 : 8'h0F, (i % 40) / 4)) begin
        err_cnt++;
        $display("FAIL b2b_txd cycle %0d: got %b", i, cap[1 + i]);
      end
    end
    cmp_cnt++;
    if (decode(1) !== 8'hA3) begin
      err_cnt++;
      $display("FAIL b2b_byte0: got %h expected a3", decode(1));
    end
    cmp_cnt++;
    if (decode(41) !== 8'h0F) begin
      err_cnt++;
      $display("FAIL b2b_byte1: got %h expected 0f", decode(41));
    end
    check_status("b2b_busy_end", 8'h06);
    tick();
    check_status("b2b_idle", 8'h02);
    $display("test_back_to_back done");
  endtask

  task automatic check_frames(input string name, input int n, input logic [7:0] exp [6]);
    for (int f = 0; f < n; f++) begin
      cmp_cnt++;
      if (decode(1 + 40 * f) !== exp[f] || cap[1 + 40 * f] !== 1'b0 || cap[1 + 40 * f + 37] !== 1'b1) begin
        err_cnt++;
        $display("FAIL %s frame %0d: byte got %h expected %h, start %b stop %b",
                 name, f, decode(1 + 40 * f), exp[f], cap[1 + 40 * f], cap[1 + 40 * f + 37]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] d [6]   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [2:0] lv [6]  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    cap_n = 0;
    for (int i = 0; i < 6; i++) begin
      write_byte(d[i]);
      check_level($sformatf("ovf_level_%0d", i), lv[i]);
      if (i == 4) check_status("ovf_full", 8'h05);
    end
    check_status("ovf_set", 8'h0D);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_status("ovf_cleared", 8'h05);
    while (cap_n < 202) tick();
    check_frames("ovf", 5, d);
    check_status("ovf_drained", 8'h02);
    $display("test_overflow done");
  endtask

  task automatic test_pop_write;
    logic [7:0] d [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h77};
    cap_n = 0;
    for (int i = 0; i < 5; i++) write_byte(d[i]);
    while (cap_n < 41) tick();
    check_level("popwr_pre", 3'd4);
    write_byte(d[5]);
    check_level("popwr_level", 3'd4);
    check_status("popwr_status", 8'h05);
    while (cap_n < 242) tick();
    check_frames("popwr", 6, d);
    check_status("popwr_drained", 8'h02);
    $display("test_pop_write done");
  endtask

  task automatic test_clr_vs_drop;
    cap_n = 0;
    for (int i = 0; i < 5; i++) write_byte(8'hB1 + 8'(i));
    clr_ovf = 1'b1;
    write_byte(8'hB6);
    clr_ovf = 1'b0;
    check_status("clrdrop_set_wins", 8'h0D);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_status("clrdrop_clear", 8'h05);
    while (cap_n < 202) tick();
    cmp_cnt++;
    if (decode(1) !== 8'hB1 || decode(161) !== 8'hB5) begin
      err_cnt++;
      $display("FAIL clrdrop_bytes: got %h/%h expected b1/b5", decode(1), decode(161));
    end
    check_status("clrdrop_drained", 8'h02);
    $display("test_clr_vs_drop done");
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_pop_write();
    test_clr_vs_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
